// File: rtl/mips_32_pkg.sv
// Shared definitions for the mips_32 single-cycle core.
// Holds the opcode and funct constants, the ALU operation set, the memory depths and the boot ROM.
package mips_32_pkg;

    localparam int unsigned IMEM_DEPTH = 64;
    localparam int unsigned DMEM_DEPTH = 64;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ZERO = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_SLT  = 3'd5
    } alu_op_e;

    // Boot program; every unlisted word is 0, which decodes as a NOP.
    function automatic logic [31:0] rom_word(input logic [5:0] idx);
        case (idx)
            6'd0:    rom_word = 32'h2001_0005; // addi $1,$0,5
            6'd1:    rom_word = 32'h2002_0003; // addi $2,$0,3
            6'd2:    rom_word = 32'h0022_1820; // add  $3,$1,$2
            6'd3:    rom_word = 32'h0022_2022; // sub  $4,$1,$2
            6'd4:    rom_word = 32'h0022_2824; // and  $5,$1,$2
            6'd5:    rom_word = 32'h0022_3025; // or   $6,$1,$2
            6'd6:    rom_word = 32'h0041_382A; // slt  $7,$2,$1
            6'd7:    rom_word = 32'hAC03_0000; // sw   $3,0($0)
            6'd8:    rom_word = 32'h8C08_0000; // lw   $8,0($0)
            6'd9:    rom_word = 32'h1103_0001; // beq  $8,$3,+1
            6'd10:   rom_word = 32'h2009_0063; // addi $9,$0,99
            6'd11:   rom_word = 32'h0800_0000; // j    0
            default: rom_word = '0;
        endcase
    endfunction

endpackage

// File: rtl/mips_32_alu.sv
// 32-bit ALU for mips_32: wrap-around add/sub, bitwise and/or, signed set-less-than.
// zero_o flags an all-zero result and drives the beq decision.
module mips_alu
    import mips_32_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  alu_op_i,
    output logic [31:0] y_o,
    output logic        zero_o
);

    always_comb begin
        y_o = '0;
        case (alu_op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_SLT: y_o = {31'd0, ($signed(a_i) < $signed(b_i))};
            default: y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);

endmodule

// File: rtl/mips_32.sv
// Single-cycle MIPS32 subset core: one instruction commits per clock, with the ROM and data RAM held internally.
// result is the ALU output of the instruction currently addressed by the PC.
module mips_32
    import mips_32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] result
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] dmem_q [DMEM_DEPTH];

    logic [31:0] instr, pc_plus4, imm_ext, rs_val, rt_val, alu_b, alu_y, wr_data;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wr_addr;
    logic [2:0]  alu_op;
    logic        use_imm, reg_write, sel_rd, mem_write, mem_to_reg, is_beq, is_j, alu_zero;

    assign instr   = rom_word(pc_q[7:2]);
    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign imm_ext = {{16{instr[15]}}, instr[15:0]};

    always_comb begin
        alu_op     = ALU_ZERO;
        use_imm    = 1'b0;
        reg_write  = 1'b0;
        sel_rd     = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                sel_rd    = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin alu_op = ALU_ADD; use_imm = 1'b1; reg_write = 1'b1; end
            OP_LW:   begin alu_op = ALU_ADD; use_imm = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1; end
            OP_SW:   begin alu_op = ALU_ADD; use_imm = 1'b1; mem_write = 1'b1; end
            OP_BEQ:  begin alu_op = ALU_SUB; is_beq = 1'b1; end
            OP_J:    is_j = 1'b1;
            default: ;
        endcase
    end

    assign rs_val = (rs == 5'd0) ? '0 : regs_q[rs];
    assign rt_val = (rt == 5'd0) ? '0 : regs_q[rt];
    assign alu_b  = use_imm ? imm_ext : rt_val;

    mips_alu u_alu (
        .a_i      (rs_val),
        .b_i      (alu_b),
        .alu_op_i (alu_op),
        .y_o      (alu_y),
        .zero_o   (alu_zero)
    );

    assign result  = alu_y;
    assign wr_addr = sel_rd ? rd : rt;
    assign wr_data = mem_to_reg ? dmem_q[alu_y[7:2]] : alu_y;

    // Next PC is masked to the ROM span so fetches alias every 256 bytes.
    assign pc_plus4 = pc_q + 32'd4;
    always_comb begin
        pc_d = pc_plus4;
        if (is_j)
            pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (is_beq && alu_zero)
            pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
        pc_d = pc_d & 32'h0000_00FF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (reg_write && wr_addr != 5'd0) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
        end else if (mem_write) begin
            dmem_q[alu_y[7:2]] <= rt_val;
        end
    end

endmodule

// File: tb/tb_mips_32.sv
// Directed bench for mips_32: checks reset state, the boot-program result sequence,
// the skipped branch target, store/load, the $0 register and a mid-run asynchronous reset.
module tb_mips_32;

    logic        clk;
    logic        reset;
    logic [31:0] result;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mips_32 dut (
        .clk    (clk),
        .reset  (reset),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Expected result per committed word, in execution order: words 0..9 then 11 (word 10 skipped).
    logic [31:0] exp_seq [11] = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7, 32'd1,
                                  32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] exp_pc  [11] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24,
                                  32'd28, 32'd32, 32'd36, 32'd44};

    initial begin
        logic found;
        logic [31:0] reg_or;

        reset = 1'b1;
        repeat (9) begin
            @(negedge clk);
            #1;
            chk("rst_pc", dut.pc_q, 32'd0);
            chk("rst_result", result, 32'd5);
        end
        #9;
        reset = 1'b0;
        #1;

        for (int k = 0; k < 33; k++) begin
            chk("seq_result", result, exp_seq[k % 11]);
            chk("seq_pc", dut.pc_q, exp_pc[k % 11]);
            chk("r0_zero", dut.regs_q[0], 32'd0);
            chk("not99", {31'd0, result == 32'd99}, 32'd0);
            if ((k % 11) == 9) begin
                chk("dmem0", dut.dmem_q[0], 32'd8);
                chk("r8_load", dut.regs_q[8], 32'd8);
            end
            @(posedge clk);
            #1;
        end
        chk("r9_untouched", dut.regs_q[9], 32'd0);
        chk("r3_add", dut.regs_q[3], 32'd8);
        chk("r4_sub", dut.regs_q[4], 32'd2);
        chk("r7_slt", dut.regs_q[7], 32'd1);

        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (dut.pc_q == 32'd20) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("reach_pc20", {31'd0, found}, 32'd1);

        #2;
        reset = 1'b1;
        #1;
        chk("midrst_pc", dut.pc_q, 32'd0);
        chk("midrst_result", result, 32'd5);
        reg_or = '0;
        for (int i = 0; i < 32; i++) reg_or = reg_or | dut.regs_q[i];
        chk("midrst_regs", reg_or, 32'd0);
        chk("midrst_dmem0", dut.dmem_q[0], 32'd0);

        @(posedge clk);
        #1;
        chk("midrst_hold_pc", dut.pc_q, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("restart_result", result, exp_seq[k]);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
